// File: rtl/dac_pkg.sv
// dac_pkg: frame layout constants and receiver state encoding shared by the DAC link TX and RX.
package dac_pkg;
  localparam int DAC_FRAME_BITS = 16;
  localparam int CFG_LSB = 0;
  localparam int CFG_W = 4;
  localparam int SAMPLE_LSB = 4;
  localparam int PAD_W = 2;
  typedef enum logic [1:0] {RESYNC, IDLE, SHIFT} dac_rx_state_t;
endpackage

// File: rtl/dac_frame_rx_sync_edge.sv
// sync_edge: multi-stage input synchroniser with rise/fall pulses taken from the synchronised level.
module sync_edge #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic prev_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign q_o = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/dac_frame_rx.sv
// dac_frame_rx: oversampling 3-wire DAC link receiver, LSB-first frames to a valid/ready sample output.
// Define DAC_RX_STATS_EN to add good-frame and frame-error counters.
module dac_frame_rx
  import dac_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int FRAME_BITS = DAC_FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic             ipClk,
  input  logic             ipReset,
  input  logic             ipSCK,
  input  logic             ipCS,
  input  logic             ipSDI,
  input  logic             ipReady,
  output logic             opValid,
  output logic [WIDTH-1:0] opData,
  output logic [3:0]       opConfig,
  output logic             opFrameErr,
  output logic             opOverflow,
`ifdef DAC_RX_STATS_EN
  output logic [15:0]      opFrameCount,
  output logic [15:0]      opErrCount,
`endif
  output logic             opBusy
);
  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam int IW = $clog2(FRAME_BITS);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_FULL = cnt_t'(FRAME_BITS);
  localparam cnt_t CNT_MAX = cnt_t'(FRAME_BITS + 1);
  localparam cnt_t CNT_FLUSH = cnt_t'(SYNC_STAGES);
  logic sck_lvl, sck_rise, sck_fall, cs_lvl, cs_rise, cs_fall, sdi, good, load, unused_sck;
  logic [SYNC_STAGES-1:0] sdi_q;
  dac_rx_state_t state_q, state_d;
  cnt_t cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] word_q, word_d;
  logic done_q, done_d;
  logic valid_q, valid_d, err_q, err_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0] cfg_q, cfg_d;
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk_i(ipClk), .rst_i(ipReset), .d_i(ipSCK), .q_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk_i(ipClk), .rst_i(ipReset), .d_i(ipCS), .q_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  assign unused_sck = sck_lvl ^ sck_fall;
  assign sdi = sdi_q[SYNC_STAGES-1];
  // Frames are evaluated one cycle after the CS rise, so word/count hold their final values here.
  assign good = (cnt_q == CNT_FULL) && (word_q[FRAME_BITS-1 -: PAD_W] == '0);
  assign load = done_q & good & (~valid_q | ipReady);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    word_d = word_q;
    done_d = 1'b0;
    unique case (state_q)
      RESYNC: begin
        // Wait for the synchroniser to refill with live pin values before trusting CS high.
        cnt_d = (cnt_q == CNT_FLUSH) ? cnt_q : cnt_q + 1'b1;
        state_d = (cnt_q == CNT_FLUSH && cs_lvl) ? IDLE : RESYNC;
      end
      IDLE: begin
        if (cs_fall) begin
          cnt_d = '0;
          word_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          done_d = 1'b1;
        end else if (sck_rise && !cs_lvl) begin
          if (cnt_q < CNT_FULL) word_d[cnt_q[IW-1:0]] = sdi;
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
      end
      default: state_d = RESYNC;
    endcase
    valid_d = load | (valid_q & ~ipReady);
    data_d = load ? word_q[SAMPLE_LSB +: WIDTH] : data_q;
    cfg_d = load ? word_q[CFG_LSB +: CFG_W] : cfg_q;
    err_d = done_q & ~good;
    ovf_d = done_q & good & valid_q & ~ipReady;
  end
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      sdi_q <= '0;
      state_q <= RESYNC;
      cnt_q <= '0;
      word_q <= '0;
      done_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= '0;
      cfg_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sdi_q <= {sdi_q[SYNC_STAGES-2:0], ipSDI};
      state_q <= state_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      done_q <= done_d;
      valid_q <= valid_d;
      data_q <= data_d;
      cfg_q <= cfg_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end
`ifdef DAC_RX_STATS_EN
  logic [15:0] frame_cnt_q, err_cnt_q;
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      frame_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (done_q && good) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_d) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end
  assign opFrameCount = frame_cnt_q;
  assign opErrCount = err_cnt_q;
`endif
  assign opValid = valid_q;
  assign opData = data_q;
  assign opConfig = cfg_q;
  assign opFrameErr = err_q;
  assign opOverflow = ovf_q;
  assign opBusy = (state_q == SHIFT);
endmodule

// File: tb/tb_dac_frame_rx.sv
// tb_dac_frame_rx: directed frames over the 3-wire link with hand-computed expected outputs.
module tb_dac_frame_rx;
  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, cs = 1'b1, sdi = 1'b0, rdy = 1'b0;
  logic valid, err, ovf, busy, v3, v4;
  logic [9:0] data;
  logic [3:0] cfg;
  int pass_cnt = 0, chk_cnt = 0, err_n = 0, ovf_n = 0, e0, o0;
`ifdef DAC_RX_STATS_EN
  logic [15:0] frame_count, err_count;
`endif
  dac_frame_rx dut (
    .ipClk(clk), .ipReset(rst), .ipSCK(sck), .ipCS(cs), .ipSDI(sdi), .ipReady(rdy),
    .opValid(valid), .opData(data), .opConfig(cfg), .opFrameErr(err), .opOverflow(ovf),
`ifdef DAC_RX_STATS_EN
    .opFrameCount(frame_count), .opErrCount(err_count),
`endif
    .opBusy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (err) err_n++;
    if (ovf) ovf_n++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic start_bits(input logic [31:0] w, input int n);
    cs = 1'b0;
    tick(4);
    for (int i = 0; i < n; i++) begin
      sdi = w[i];
      tick(4);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
    tick(4);
  endtask
  task automatic end_frame(input logic r);
    cs = 1'b1;
    tick(3);
    v3 = valid;
    rdy = r;
    tick(1);
    v4 = valid;
    rdy = 1'b0;
    tick(4);
  endtask
  task automatic send(input logic [31:0] w, input int n, input logic r);
    e0 = err_n;
    o0 = ovf_n;
    start_bits(w, n);
    end_frame(r);
  endtask
  task automatic consume();
    rdy = 1'b1;
    tick(1);
    rdy = 1'b0;
  endtask
  initial begin
    tick(3);
    check("rst_valid", 32'(valid), 0);
    check("rst_data", 32'(data), 0);
    check("rst_cfg", 32'(cfg), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick(5);
    e0 = err_n;
    start_bits(32'h2ABC, 16);
    check("busy_shift", 32'(busy), 1);
    end_frame(1'b0);
    check("lat_v3", 32'(v3), 0);
    check("lat_v4", 32'(v4), 1);
    check("t1_data", 32'(data), 32'h2AB);
    check("t1_cfg", 32'(cfg), 32'hC);
    check("t1_err", 32'(err_n - e0), 0);
    check("busy_idle", 32'(busy), 0);
    tick(10);
    check("t1_hold_valid", 32'(valid), 1);
    check("t1_hold_data", 32'(data), 32'h2AB);
    consume();
    check("t1_consumed", 32'(valid), 0);
    send(32'hFFF, 12, 1'b0);
    check("short_err", 32'(err_n - e0), 1);
    check("short_valid", 32'(valid), 0);
    send(32'h3FF0, 16, 1'b0);
    check("t2_data", 32'(data), 32'h3FF);
    check("t2_cfg", 32'(cfg), 0);
    check("t2_valid", 32'(valid), 1);
    consume();
    send(32'hC005, 16, 1'b0);
    check("pad_err", 32'(err_n - e0), 1);
    check("pad_valid", 32'(valid), 0);
    send(32'h0014, 18, 1'b0);
    check("long_err", 32'(err_n - e0), 1);
    check("long_valid", 32'(valid), 0);
    send(32'h0014, 16, 1'b0);
    send(32'h0028, 16, 1'b0);
    check("ovf_pulse", 32'(ovf_n - o0), 1);
    check("ovf_data", 32'(data), 32'h001);
    check("ovf_cfg", 32'(cfg), 32'h4);
    check("ovf_valid", 32'(valid), 1);
    consume();
    send(32'h0014, 16, 1'b0);
    send(32'h0028, 16, 1'b1);
    check("swap_ovf", 32'(ovf_n - o0), 0);
    check("swap_data", 32'(data), 32'h002);
    check("swap_cfg", 32'(cfg), 32'h8);
    check("swap_valid", 32'(valid), 1);
    consume();
    e0 = err_n;
    start_bits(32'hFF, 8);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(6);
    check("midrst_valid", 32'(valid), 0);
    check("midrst_busy", 32'(busy), 0);
    cs = 1'b1;
    tick(8);
    check("midrst_err", 32'(err_n - e0), 0);
    send(32'h1234, 16, 1'b0);
    check("midrst_err2", 32'(err_n - e0), 0);
    check("midrst_data", 32'(data), 32'h123);
    check("midrst_cfg", 32'(cfg), 32'h4);
    check("midrst_vld", 32'(valid), 1);
    consume();
`ifdef DAC_RX_STATS_EN
    check("stat_frames0", 32'(frame_count), 1);
    check("stat_errs0", 32'(err_count), 0);
    send(32'h0100, 16, 1'b1);
    send(32'h4000, 16, 1'b1);
    send(32'h0200, 16, 1'b1);
    send(32'h0300, 8, 1'b1);
    send(32'h0310, 16, 1'b1);
    check("stat_frames", 32'(frame_count), 4);
    check("stat_errs", 32'(err_count), 2);
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
